// File: rtl/led_strand_driver.sv
// led_strand_driver: WS2812-style single-wire transmitter fetching GRB colors per LED with one-deep prefetch.
// Optional macro LED_DRIVER_STATUS_EN adds the saturating underrun_count_o status port.
module led_strand_driver #(
    parameter int NUM_LEDS          = 50,
    parameter int LED_ADDRESS_WIDTH = $clog2(NUM_LEDS),
    parameter int T0H_CYCLES        = 35,
    parameter int T0L_CYCLES        = 80,
    parameter int T1H_CYCLES        = 70,
    parameter int T1L_CYCLES        = 60,
    parameter int RESET_CYCLES      = 5000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         go_i,
    output logic                         ready_o,
    output logic [LED_ADDRESS_WIDTH:0]   next_led_request_o,
    input  logic [7:0]                   green_i,
    input  logic [7:0]                   red_i,
    input  logic [7:0]                   blue_i,
    input  logic                         color_valid_i,
    output logic                         strand_out_o,
    output logic                         frame_done_o
`ifdef LED_DRIVER_STATUS_EN
    ,
    output logic [15:0]                  underrun_count_o
`endif
);
    localparam int AW = LED_ADDRESS_WIDTH + 1;
    localparam int TW = $clog2(RESET_CYCLES + T0H_CYCLES + T0L_CYCLES + T1H_CYCLES + T1L_CYCLES + 1);
    localparam logic [AW-1:0] NONE = AW'(NUM_LEDS);

    typedef enum logic [2:0] {IDLE, FETCH, SEND_HIGH, SEND_LOW, STALL, LATCH} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   req_q, req_d, nxt_q, nxt_d;
    logic            chg_q, chg_d;
    logic [23:0]     sh_q, sh_d, pf_q, pf_d, ld_val;
    logic            pf_vld_q, pf_vld_d, ld;
    logic [4:0]      bit_q, bit_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            strand_q, done_q;
    logic            acc;
    logic [23:0]     col;

    function automatic logic [TW-1:0] hi_t(input logic b);
        return b ? TW'(T1H_CYCLES - 1) : TW'(T0H_CYCLES - 1);
    endfunction

    function automatic logic [TW-1:0] lo_t(input logic b);
        return b ? TW'(T1L_CYCLES - 1) : TW'(T0L_CYCLES - 1);
    endfunction

    // a request is accepted only once it has been visible for a full cycle
    assign acc = color_valid_i && !chg_q && (req_q != NONE);
    assign col = {green_i, red_i, blue_i};

    assign ready_o            = (state_q == IDLE) && !done_q;
    assign next_led_request_o = req_q;
    assign strand_out_o       = strand_q;
    assign frame_done_o       = done_q;

    // next-state: fetch handshake, bit timing, prefetch reload and latch period
    always_comb begin
        state_d  = state_q;
        req_d    = acc ? NONE : req_q;
        nxt_d    = nxt_q;
        sh_d     = sh_q;
        pf_d     = pf_q;
        pf_vld_d = pf_vld_q;
        bit_d    = bit_q;
        tmr_d    = tmr_q - TW'(1);
        ld       = 1'b0;
        ld_val   = col;
        if (acc && (state_q == SEND_HIGH || state_q == SEND_LOW)) begin
            pf_d     = col;
            pf_vld_d = 1'b1;
        end
        case (state_q)
            IDLE: if (go_i && !done_q) begin
                state_d = FETCH;
                req_d   = '0;
                nxt_d   = AW'(1);
            end
            FETCH, STALL: ld = acc;
            SEND_HIGH: if (tmr_q == '0) begin
                state_d = SEND_LOW;
                tmr_d   = lo_t(sh_q[23]);
            end
            SEND_LOW: if (tmr_q == '0) begin
                if (bit_q != 5'd23) begin
                    sh_d    = sh_q << 1;
                    bit_d   = bit_q + 5'd1;
                    state_d = SEND_HIGH;
                    tmr_d   = hi_t(sh_q[22]);
                end else if (pf_vld_q || acc) begin
                    ld     = 1'b1;
                    ld_val = pf_vld_q ? pf_q : col;
                end else if (req_q != NONE) begin
                    state_d = STALL;
                end else begin
                    state_d = LATCH;
                    tmr_d   = TW'(RESET_CYCLES - 1);
                end
            end
            LATCH: if (tmr_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (ld) begin
            sh_d     = ld_val;
            bit_d    = '0;
            state_d  = SEND_HIGH;
            tmr_d    = hi_t(ld_val[23]);
            pf_vld_d = 1'b0;
            if (nxt_q != NONE) begin
                req_d = nxt_q;
                nxt_d = nxt_q + AW'(1);
            end
        end
        chg_d = (req_d != req_q) && (req_d != NONE);
    end

    // state registers; line and done pulse registered so the strand never glitches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            req_q    <= NONE;
            nxt_q    <= '0;
            chg_q    <= 1'b0;
            sh_q     <= '0;
            pf_q     <= '0;
            pf_vld_q <= 1'b0;
            bit_q    <= '0;
            tmr_q    <= '0;
            strand_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            nxt_q    <= nxt_d;
            chg_q    <= chg_d;
            sh_q     <= sh_d;
            pf_q     <= pf_d;
            pf_vld_q <= pf_vld_d;
            bit_q    <= bit_d;
            tmr_q    <= tmr_d;
            strand_q <= (state_d == SEND_HIGH);
            done_q   <= (state_q == LATCH) && (tmr_q == '0);
        end
    end

`ifdef LED_DRIVER_STATUS_EN
    logic [15:0] und_q;

    assign underrun_count_o = und_q;

    // count stall entries, saturating; restart at each accepted go
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            und_q <= '0;
        end else if (state_q == IDLE && state_d == FETCH) begin
            und_q <= '0;
        end else if (state_q != STALL && state_d == STALL && und_q != 16'hFFFF) begin
            und_q <= und_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_led_strand_driver.sv
// tb_led_strand_driver: directed checks of frame timing, fetch handshake, stalls, abort and go handling.
module tb_led_strand_driver;
    localparam int N    = 3;
    localparam int T0H  = 2;
    localparam int T0L  = 4;
    localparam int T1H  = 4;
    localparam int T1L  = 2;
    localparam int RSTC = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       go;
    logic       ready;
    logic [2:0] req;
    logic [7:0] green, red, blue;
    logic       color_valid;
    logic       strand;
    logic       frame_done;
`ifdef LED_DRIVER_STATUS_EN
    logic [15:0] underrun;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int mode   = 0;
    logic [23:0] leds [N];
    int hi_len[$];
    int lo_len[$];

    led_strand_driver #(
        .NUM_LEDS(N), .T0H_CYCLES(T0H), .T0L_CYCLES(T0L),
        .T1H_CYCLES(T1H), .T1L_CYCLES(T1L), .RESET_CYCLES(RSTC)
    ) dut (
        .clk(clk), .rst(rst), .go_i(go), .ready_o(ready),
        .next_led_request_o(req), .green_i(green), .red_i(red), .blue_i(blue),
        .color_valid_i(color_valid), .strand_out_o(strand), .frame_done_o(frame_done)
`ifdef LED_DRIVER_STATUS_EN
        , .underrun_count_o(underrun)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // color source: mode 0 instant, 1 answers 200 cycles after a request change,
    // 3 drives junk when idle and in the change cycle, real data 5 cycles later
    initial begin
        logic [2:0]  prev;
        int          age;
        logic [23:0] d;
        logic        v;
        prev = 3'd3;
        age = 0;
        color_valid = 1'b0;
        {green, red, blue} = 24'h0;
        forever begin
            @(posedge clk);
            #1;
            if (req != prev) begin
                prev = req;
                age = 0;
            end else if (age < 100000) begin
                age++;
            end
            d = (req < 3'd3) ? leds[req] : 24'h5A5A5A;
            case (mode)
                0: v = (req != 3'd3);
                1: v = (req != 3'd3) && (age >= 200);
                default: begin
                    v = (req == 3'd3) || (age == 0) || (age >= 5);
                    if (req != 3'd3 && age == 0) d = ~d;
                end
            endcase
            color_valid = v;
            {green, red, blue} = d;
        end
    end

    task automatic capture(input int budget);
        int  cyc;
        int  h;
        int  l;
        bit  seen;
        hi_len.delete();
        lo_len.delete();
        cyc = 0; h = 0; l = 0; seen = 0;
        while (!seen && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (frame_done) begin
                seen = 1;
            end else if (strand) begin
                if (l > 0) begin
                    hi_len.push_back(h);
                    lo_len.push_back(l);
                    h = 0;
                    l = 0;
                end
                h++;
            end else if (h > 0) begin
                l++;
            end
        end
        if (h > 0) begin
            hi_len.push_back(h);
            lo_len.push_back(l);
        end
        check("frame_done_seen", seen, 1);
    endtask

    task automatic verify_frame(input string tag, input bit exact_lows);
        logic [71:0] e;
        logic        b;
        e = {leds[0], leds[1], leds[2]};
        check({tag, "_bits"}, hi_len.size(), 72);
        for (int i = 0; i < hi_len.size() && i < 72; i++) begin
            b = e[71-i];
            check($sformatf("%s_hi%0d", tag, i), hi_len[i], b ? T1H : T0H);
            if (i == 71)
                check({tag, "_latch_low"}, lo_len[i], (b ? T1L : T0L) + RSTC);
            else if (exact_lows || (i % 24) != 23)
                check($sformatf("%s_lo%0d", tag, i), lo_len[i], b ? T1L : T0L);
        end
    endtask

    task automatic start_frame();
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check("ready_drop", ready, 0);
        check("req_led0", req, 0);
    endtask

    task automatic after_frame();
        @(negedge clk);
        check("done_single", frame_done, 0);
        check("ready_back", ready, 1);
        check("req_idle", req, 3);
    endtask

    initial begin
        int rises;
        int fd_cnt;
        logic prev_s;
        rst = 1'b1;
        go = 1'b0;
        leds[0] = 24'hFF0000; leds[1] = 24'h00FF00; leds[2] = 24'h0000A5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_strand", strand, 0);
        check("rst_req", req, 3);
        check("rst_done", frame_done, 0);
        rst = 1'b0;

        start_frame();
        capture(2000);
        verify_frame("basic", 1);
`ifdef LED_DRIVER_STATUS_EN
        check("underrun_fast", underrun, 0);
`endif
        after_frame();

        leds[0] = 24'h800001; leds[1] = 24'h123456; leds[2] = 24'hABCDEF;
        start_frame();
        capture(2000);
        verify_frame("pattern", 1);
        after_frame();

        mode = 1;
        leds[0] = 24'hFFFFFF; leds[1] = 24'hFFFFFF; leds[2] = 24'hFFFFFF;
        start_frame();
        capture(5000);
        verify_frame("slow", 0);
        if (lo_len.size() == 72) begin
            check("stall0_long", lo_len[23] > T1L, 1);
            check("stall1_long", lo_len[47] > T1L, 1);
        end
`ifdef LED_DRIVER_STATUS_EN
        check("underrun_slow", underrun, 2);
`endif
        after_frame();

        mode = 3;
        leds[0] = 24'h0F0F0F; leds[1] = 24'hF0F0F0; leds[2] = 24'h3C3C3C;
        repeat (6) @(negedge clk);
        check("spur_idle_req", req, 3);
        check("spur_idle_ready", ready, 1);
        start_frame();
        capture(3000);
        verify_frame("spurious", 1);
`ifdef LED_DRIVER_STATUS_EN
        check("underrun_cleared", underrun, 0);
`endif
        after_frame();

        mode = 0;
        leds[0] = 24'hFF0000; leds[1] = 24'h00FF00; leds[2] = 24'h0000A5;
        start_frame();
        rises = 0;
        prev_s = 1'b0;
        for (int c = 0; c < 1000 && rises < 35; c++) begin
            @(negedge clk);
            if (strand && !prev_s) rises++;
            prev_s = strand;
        end
        check("abort_reached", rises, 35);
        rst = 1'b1;
        #1;
        check("abort_strand", strand, 0);
        check("abort_req", req, 3);
        check("abort_ready", ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fd_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (frame_done) fd_cnt++;
        end
        check("abort_no_done", fd_cnt, 0);
        start_frame();
        capture(2000);
        verify_frame("after_abort", 1);
        after_frame();

        @(negedge clk);
        go = 1'b1;
        capture(2000);
        verify_frame("go_held", 1);
        check("held_ready_done", ready, 0);
        @(negedge clk);
        check("held_done_once", frame_done, 0);
        check("held_ready_up", ready, 1);
        check("held_req_idle", req, 3);
        @(negedge clk);
        go = 1'b0;
        check("held_restart", ready, 0);
        check("held_req0", req, 0);
        capture(2000);
        verify_frame("second", 1);
        after_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
